// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue stage in front of a combinational 64-bit ALU. Requests are queued
//   in an in-order FIFO. The head entry drives the ALU operand and control
//   outputs. Each ALU result is captured with its tag into an output register
//   that is released through a valid/ready handshake.
//
//   Optional feature macro: ALU_FLAGS_EN. When it is defined, the block adds
//   the out_zero_o and out_neg_o result flag ports.
//
//   Ports
//     clk_i, rst_i               clock (rising edge) and synchronous active-high reset
//     in_valid_i / in_ready_o    request handshake; in_ready_o = (count < DEPTH)
//     in_control_i               ALU op: 00 add, 01 sub, 10 and, 11 or
//     in_a_i, in_b_i, in_tag_i   operands and opaque tag
//     alu_control_o/a_o/b_o      head entry to the ALU; 0 when the FIFO is empty
//     alu_y_i                    ALU result (combinational from alu_*)
//     out_valid_o / out_ready_i  result handshake
//     out_y_o, out_tag_o         captured result and its tag
//     count_o                    FIFO occupancy, 0..DEPTH
//     out_zero_o, out_neg_o      (ALU_FLAGS_EN only) out_y == 0, out_y sign bit
module alu_issue_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               in_control_i,
    input  logic [WIDTH-1:0]         in_a_i,
    input  logic [WIDTH-1:0]         in_b_i,
    input  logic [TAG_W-1:0]         in_tag_i,
    output logic [1:0]               alu_control_o,
    output logic [WIDTH-1:0]         alu_a_o,
    output logic [WIDTH-1:0]         alu_b_o,
    input  logic [WIDTH-1:0]         alu_y_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_y_o,
    output logic [TAG_W-1:0]         out_tag_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef ALU_FLAGS_EN
    ,
    output logic                     out_zero_o,
    output logic                     out_neg_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

    logic [1:0]       ctrl_mem_q [DEPTH];
    logic [WIDTH-1:0] a_mem_q    [DEPTH];
    logic [WIDTH-1:0] b_mem_q    [DEPTH];
    logic [TAG_W-1:0] tag_mem_q  [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_y_q;
    logic [TAG_W-1:0] out_tag_q;

    logic push, pop, fifo_nempty;

    // in_ready comes from the registered count only, so a pop at full does
    // not open the input in the same cycle.
    assign in_ready_o  = (count_q < DEPTH_C);
    assign push        = in_valid_i & in_ready_o;
    assign fifo_nempty = (count_q != '0);

    // Output register FSM
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready_i) begin
                    if (fifo_nempty) pop = 1'b1;
                    else             state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Storage has no reset; only the pointers and count define what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ctrl_mem_q[wr_ptr_q] <= in_control_i;
            a_mem_q[wr_ptr_q]    <= in_a_i;
            b_mem_q[wr_ptr_q]    <= in_b_i;
            tag_mem_q[wr_ptr_q]  <= in_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_EMPTY;
            out_y_q   <= '0;
            out_tag_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            if (pop) begin
                out_y_q   <= alu_y_i;
                out_tag_q <= tag_mem_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        alu_control_o = '0;
        alu_a_o       = '0;
        alu_b_o       = '0;
        if (fifo_nempty) begin
            alu_control_o = ctrl_mem_q[rd_ptr_q];
            alu_a_o       = a_mem_q[rd_ptr_q];
            alu_b_o       = b_mem_q[rd_ptr_q];
        end
    end

    assign out_valid_o = (state_q == S_FULL);
    assign out_y_o     = out_y_q;
    assign out_tag_o   = out_tag_q;
    assign count_o     = count_q;

`ifdef ALU_FLAGS_EN
    logic out_zero_q, out_neg_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_zero_q <= 1'b0;
            out_neg_q  <= 1'b0;
        end else if (pop) begin
            out_zero_q <= (alu_y_i == '0);
            out_neg_q  <= alu_y_i[WIDTH-1];
        end
    end

    assign out_zero_o = out_zero_q;
    assign out_neg_o  = out_neg_q;
`else
    // Flag ports and registers are not built.
`endif

endmodule
